// File: rtl/rr_stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package rr_stream_mux_pkg;

   typedef enum logic {
      StEmpty,
      StFull
   } out_state_e;

   // Channel-index width; a single channel still needs a 1-bit index.
   function automatic int unsigned ch_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_stream_mux_if.sv
// Producer-side and consumer-side valid/ready bundle of rr_stream_mux.
interface rr_stream_mux_if
   import rr_stream_mux_pkg::*;
#(
   parameter int unsigned N_CH = 4,
   parameter int unsigned W    = 4
);
   localparam int unsigned CH_W = ch_width(N_CH);

   logic [N_CH-1:0]   in_valid;
   logic [N_CH*W-1:0] in_data;
   logic [N_CH-1:0]   in_ready;
   logic              out_valid;
   logic [W-1:0]      out_data;
   logic [CH_W-1:0]   out_ch;
   logic              out_ready;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_ch,
      output out_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data,
      output out_ch,
      input  out_ready
   );

endinterface

// File: rtl/rr_stream_mux_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping at N_CH.
module rr_stream_mux_arbiter
   import rr_stream_mux_pkg::*;
#(
   parameter int unsigned N_CH = 4,
   localparam int unsigned CH_W = ch_width(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [CH_W-1:0] ptr,
   output logic            grant_valid,
   output logic [CH_W-1:0] grant_idx
);

   logic            hi_valid;
   logic [CH_W-1:0] hi_idx;
   logic            lo_valid;
   logic [CH_W-1:0] lo_idx;

   // Scan downwards so the lowest matching index is the one left standing.
   // hi_* only sees channels >= ptr; lo_* sees all and covers the wrap.
   always_comb begin
      hi_valid = 1'b0;
      hi_idx   = '0;
      lo_valid = 1'b0;
      lo_idx   = '0;
      for (int i = int'(N_CH) - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_valid = 1'b1;
            lo_idx   = CH_W'(i);
            if (CH_W'(i) >= ptr) begin
               hi_valid = 1'b1;
               hi_idx   = CH_W'(i);
            end
         end
      end
   end

   always_comb begin
      grant_valid = lo_valid;
      grant_idx   = hi_valid ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel round-robin stream multiplexer with a one-deep registered output stage.
module rr_stream_mux
   import rr_stream_mux_pkg::*;
#(
   parameter int unsigned N_CH = 4,
   parameter int unsigned W    = 4
) (
   input  logic          clk,
   input  logic          rst,
   rr_stream_mux_if.slave bus
);

   localparam int unsigned CH_W = ch_width(N_CH);

   out_state_e      state_q, state_d;
   logic [CH_W-1:0] ptr_q, ptr_d;
   logic [W-1:0]    data_q;
   logic [CH_W-1:0] ch_q;

   logic            grant_valid;
   logic [CH_W-1:0] grant_idx;
   logic            load;
   logic            xfer;
   logic [W-1:0]    sel_data;

   rr_stream_mux_arbiter #(
      .N_CH (N_CH)
   ) u_arbiter (
      .req         (bus.in_valid),
      .ptr         (ptr_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // Reset gates acceptance so nothing is handshaken while the block is held in reset.
   always_comb begin
      load = ((state_q == StEmpty) || bus.out_ready) && !rst;
      xfer = load && grant_valid;
   end

   // Only the granted lane is ever steered, so other lanes' data cannot leak out.
   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (CH_W'(i) == grant_idx) begin
            sel_data = bus.in_data[i*W +: W];
         end
      end
   end

   always_comb begin
      if (grant_idx == CH_W'(N_CH - 1)) begin
         ptr_d = '0;
      end else begin
         ptr_d = grant_idx + CH_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StEmpty: begin
            if (xfer) begin
               state_d = StFull;
            end
         end
         StFull: begin
            if (bus.out_ready && !xfer) begin
               state_d = StEmpty;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   always_comb begin
      bus.out_valid = (state_q == StFull);
      bus.out_data  = data_q;
      bus.out_ch    = ch_q;
      for (int unsigned i = 0; i < N_CH; i++) begin
         bus.in_ready[i] = xfer && (CH_W'(i) == grant_idx);
      end
   end

   // A drain with no refill leaves data and channel holding their last values.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         ch_q   <= '0;
         ptr_q  <= '0;
      end else if (xfer) begin
         data_q <= sel_data;
         ch_q   <= grant_idx;
         ptr_q  <= ptr_d;
      end
   end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed self-checking bench for rr_stream_mux (N_CH=4, W=4).
module tb_rr_stream_mux;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   rr_stream_mux_if #(
      .N_CH (4),
      .W    (4)
   ) bus ();

   rr_stream_mux #(
      .N_CH (4),
      .W    (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [3:0] d,
                             input logic [1:0] ch);
      chk({tag, "_valid"}, 16'(bus.out_valid), 16'(v));
      chk({tag, "_data"}, 16'(bus.out_data), 16'(d));
      chk({tag, "_ch"}, 16'(bus.out_ch), 16'(ch));
   endtask

   task automatic expect_ready(input string tag, input logic [3:0] r);
      chk({tag, "_in_ready"}, 16'(bus.in_ready), 16'(r));
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 4'b1111;
      bus.in_data   = 16'hDCBA;
      bus.out_ready = 1'b1;

      // Reset held two cycles with every channel requesting.
      tick();
      tick();
      expect_out("reset", 1'b0, 4'h0, 2'd0);
      expect_ready("reset", 4'b0000);

      rst = 1'b0;
      #1;
      expect_ready("first_grant", 4'b0001);

      // Round robin with all channels valid: A,B,C,D,A with no bubbles.
      for (int k = 0; k < 5; k++) begin
         tick();
         expect_out($sformatf("rr%0d", k), 1'b1, 4'hA + 4'(k % 4), 2'(k % 4));
      end

      tick();
      expect_out("pre_stall", 1'b1, 4'hB, 2'd1);

      // Backpressure: output and channel frozen, no input accepted.
      bus.out_ready = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         expect_ready($sformatf("stall%0d", k), 4'b0000);
         tick();
         expect_out($sformatf("stall%0d", k), 1'b1, 4'hB, 2'd1);
      end
      bus.out_ready = 1'b1;
      #1;
      expect_ready("unstall", 4'b0100);
      tick();
      expect_out("unstall", 1'b1, 4'hC, 2'd2);

      // Single requester on channel 2 with the search starting at 3.
      bus.in_valid       = 4'b0100;
      bus.in_data[8 +: 4] = 4'h7;
      #1;
      expect_ready("single", 4'b0100);
      tick();
      expect_out("single", 1'b1, 4'h7, 2'd2);

      // Wrap from ptr=3 to channels 0 then 1.
      bus.in_valid = 4'b0011;
      #1;
      expect_ready("wrap0", 4'b0001);
      tick();
      expect_out("wrap0", 1'b1, 4'hA, 2'd0);
      expect_ready("wrap1", 4'b0010);
      tick();
      expect_out("wrap1", 1'b1, 4'hB, 2'd1);

      // Channel 3 alone is granted twice in a row.
      bus.in_valid = 4'b1000;
      #1;
      expect_ready("ch3a", 4'b1000);
      tick();
      expect_out("ch3a", 1'b1, 4'hD, 2'd3);
      bus.in_data[12 +: 4] = 4'h9;
      #1;
      expect_ready("ch3b", 4'b1000);
      tick();
      expect_out("ch3b", 1'b1, 4'h9, 2'd3);

      // Drain without refill: valid drops, data and channel hold.
      bus.in_valid = 4'b0000;
      tick();
      expect_out("drain", 1'b0, 4'h9, 2'd3);
      tick();
      tick();
      expect_out("idle", 1'b0, 4'h9, 2'd3);

      // X on an invalid channel must never reach the output.
      bus.in_valid = 4'b0111;
      bus.in_data  = {4'bxxxx, 4'hC, 4'hB, 4'hA};
      #1;
      expect_ready("xiso", 4'b0001);
      for (int k = 0; k < 4; k++) begin
         tick();
         expect_out($sformatf("xiso%0d", k), 1'b1, 4'hA + 4'(k % 3), 2'(k % 3));
      end

      // Reset while a word is stalled: word dropped, pointer back to 0.
      bus.out_ready = 1'b0;
      #1;
      rst = 1'b1;
      tick();
      expect_out("midrst", 1'b0, 4'h0, 2'd0);
      expect_ready("midrst", 4'b0000);
      rst           = 1'b0;
      bus.in_valid  = 4'b1111;
      bus.in_data   = 16'hDCBA;
      bus.out_ready = 1'b1;
      #1;
      expect_ready("postrst", 4'b0001);
      tick();
      expect_out("postrst", 1'b1, 4'hA, 2'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
